ahb_interconnect_n: RTL and testbench

Parametrised single-master AHB-Lite interconnect for NSLV slaves. It combines address decoding, the registered data-phase response multiplexer and a built-in default slave into one block. Any address outside the mapped regions receives a two-cycle ERROR response and is logged in a saturating error counter. It sits between the AHB master and the slave array and generalises the fixed four-slave decoder/multiplexer pairing.

---
 rtl/ahb_pkg.sv | 10 +
 rtl/ahb_default_slave.sv | 45 ++++
 rtl/ahb_interconnect_n.sv | 65 ++++++
 tb/tb_ahb_interconnect_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer/response encodings and default-slave states.
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped addresses with error logging.
module ahb_default_slave
   import ahb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          sel,
   input  logic [1:0]    htrans,
   input  logic          hready,
   input  logic [AW-1:0] haddr,
   output logic          hreadyout,
   output logic          hresp,
   output logic [15:0]   err_count,
   output logic [AW-1:0] err_addr
);
   ds_state_e     state_q;
   logic [15:0]   err_count_q;
   logic [AW-1:0] err_addr_q;
   logic          active;
   logic          hit;
   assign active    = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   assign hit       = sel && active && hready;
   assign hreadyout = (state_q != DS_ERR1);
   assign hresp     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
   assign err_count = err_count_q;
   assign err_addr  = err_addr_q;
   // ERR1 is the only non-ready state, so every other state re-evaluates the address phase
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q     <= DS_IDLE;
         err_count_q <= '0;
         err_addr_q  <= '0;
      end else if (state_q == DS_ERR1) begin
         state_q <= DS_ERR2;
      end else if (hit) begin
         state_q     <= DS_ERR1;
         err_count_q <= err_count_q + {15'd0, err_count_q != 16'hFFFF};
         err_addr_q  <= haddr;
      end else begin
         state_q <= DS_IDLE;
      end
   end
endmodule

// File: rtl/ahb_interconnect_n.sv
// ahb_interconnect_n: single-master AHB-Lite decoder, registered data-phase mux and default slave.
module ahb_interconnect_n
   import ahb_pkg::*;
#(
   parameter int NSLV       = 4,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int REGION_LSB = 28
) (
   input  logic               hclk,
   input  logic               hresetn,
   input  logic [AW-1:0]      haddr,
   input  logic [1:0]         htrans,
   output logic [NSLV-1:0]    s_hsel,
   input  logic [NSLV*DW-1:0] s_hrdata,
   input  logic [NSLV-1:0]    s_hreadyout,
   input  logic [NSLV-1:0]    s_hresp,
   output logic               hready,
   output logic [DW-1:0]      hrdata,
   output logic               hresp,
   output logic [15:0]        err_count,
   output logic [AW-1:0]      err_addr
);
   localparam int DSW = $clog2(NSLV + 1);
   logic [3:0]     idx;
   logic [DSW-1:0] asel;
   logic [DSW-1:0] dsel_q;
   logic           ds_hreadyout;
   logic           ds_hresp;
   assign idx  = haddr[REGION_LSB +: 4];
   assign asel = (int'(idx) < NSLV) ? DSW'(idx) : DSW'(NSLV);
   always_comb begin
      s_hsel = '0;
      for (int i = 0; i < NSLV; i++) s_hsel[i] = (idx == 4'(i));
   end
   // dsel value NSLV routes the data phase to the default slave
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) dsel_q <= DSW'(NSLV);
      else if (hready) dsel_q <= asel;
   end
   always_comb begin
      hready = ds_hreadyout;
      hresp  = ds_hresp;
      hrdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (dsel_q == DSW'(i)) begin
            hready = s_hreadyout[i];
            hresp  = s_hresp[i];
            hrdata = s_hrdata[i*DW +: DW];
         end
      end
   end
   ahb_default_slave #(.AW(AW)) u_ds (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .sel       (asel == DSW'(NSLV)),
      .htrans    (htrans),
      .hready    (hready),
      .haddr     (haddr),
      .hreadyout (ds_hreadyout),
      .hresp     (ds_hresp),
      .err_count (err_count),
      .err_addr  (err_addr)
   );
endmodule

// File: tb/tb_ahb_interconnect_n.sv
// tb_ahb_interconnect_n: directed checks of decode, data-phase mux and default-slave errors.
module tb_ahb_interconnect_n;
   logic          hclk = 1'b0;
   logic          hresetn;
   logic [31:0]   haddr;
   logic [1:0]    htrans;
   logic [3:0]    s_hsel;
   logic [127:0]  s_hrdata;
   logic [3:0]    s_hreadyout;
   logic [3:0]    s_hresp;
   logic          hready;
   logic [31:0]   hrdata;
   logic          hresp;
   logic [15:0]   err_count;
   logic [31:0]   err_addr;
   int            vectors = 0;
   int            miscompares = 0;

   ahb_interconnect_n #(.NSLV(4), .AW(32), .DW(32), .REGION_LSB(28)) dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .haddr       (haddr),
      .htrans      (htrans),
      .s_hsel      (s_hsel),
      .s_hrdata    (s_hrdata),
      .s_hreadyout (s_hreadyout),
      .s_hresp     (s_hresp),
      .hready      (hready),
      .hrdata      (hrdata),
      .hresp       (hresp),
      .err_count   (err_count),
      .err_addr    (err_addr)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hresetn     = 1'b1;
      haddr       = 32'h2000_0000;
      htrans      = 2'b00;
      s_hreadyout = 4'hF;
      s_hresp     = 4'h0;
      s_hrdata    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      #2 hresetn = 1'b0;
      #1;
      chk("rst_hready", 32'(hready), 32'd1);
      chk("rst_hresp", 32'(hresp), 32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      chk("rst_hsel", 32'(s_hsel), 32'h4);
      tick();
      hresetn = 1'b1;

      // slave 2 read with two wait states
      tick();
      haddr = 32'h2000_0010; htrans = 2'b10;
      #1 chk("s2_hsel", 32'(s_hsel), 32'h4);
      tick();
      haddr = 32'h0; htrans = 2'b00; s_hreadyout[2] = 1'b0;
      #1 chk("s2_wait1", 32'(hready), 32'd0);
      tick();
      #1 chk("s2_wait2", 32'(hready), 32'd0);
      tick();
      s_hreadyout[2] = 1'b1;
      #1;
      chk("s2_ready", 32'(hready), 32'd1);
      chk("s2_hrdata", hrdata, 32'hCAFE_0002);
      chk("s2_hresp", 32'(hresp), 32'd0);

      // pipelined slave 1 then slave 3, slave 1 waits one cycle
      tick();
      haddr = 32'h1000_0000; htrans = 2'b10;
      tick();
      haddr = 32'h3000_0000; htrans = 2'b10; s_hreadyout[1] = 1'b0;
      #1;
      chk("p1_wait", 32'(hready), 32'd0);
      chk("p1_hrdata", hrdata, 32'hCAFE_0001);
      tick();
      s_hreadyout[1] = 1'b1; s_hreadyout[3] = 1'b0;
      #1;
      chk("p1_done_hready", 32'(hready), 32'd1);
      chk("p1_done_hrdata", hrdata, 32'hCAFE_0001);
      tick();
      haddr = 32'h0; htrans = 2'b00;
      #1;
      chk("p3_hrdata", hrdata, 32'hCAFE_0003);
      chk("p3_wait", 32'(hready), 32'd0);
      tick();
      s_hreadyout[3] = 1'b1; s_hresp[3] = 1'b1;
      #1;
      chk("p3_ready", 32'(hready), 32'd1);
      chk("p3_err_pass", 32'(hresp), 32'd1);
      tick();
      s_hresp = 4'h0;

      // unmapped NONSEQ then IDLE at the same address
      haddr = 32'h7000_0004; htrans = 2'b10;
      #1 chk("um_hsel", 32'(s_hsel), 32'h0);
      tick();
      haddr = 32'h0; htrans = 2'b00;
      #1;
      chk("um_err1_hready", 32'(hready), 32'd0);
      chk("um_err1_hresp", 32'(hresp), 32'd1);
      chk("um_err_count", 32'(err_count), 32'd1);
      chk("um_err_addr", err_addr, 32'h7000_0004);
      tick();
      #1;
      chk("um_err2_hready", 32'(hready), 32'd1);
      chk("um_err2_hresp", 32'(hresp), 32'd1);
      haddr = 32'h7000_0004; htrans = 2'b00;
      tick();
      haddr = 32'h0;
      #1;
      chk("um_idle_hready", 32'(hready), 32'd1);
      chk("um_idle_hresp", 32'(hresp), 32'd0);
      chk("um_idle_count", 32'(err_count), 32'd1);

      // counter saturation over three back-to-back unmapped transfers
      force dut.u_ds.err_count_q = 16'hFFFE;
      #1 release dut.u_ds.err_count_q;
      #1 chk("sat_preload", 32'(err_count), 32'hFFFE);
      tick();
      haddr = 32'h8000_0000; htrans = 2'b10;
      tick();
      haddr = 32'h9000_0000;
      #1;
      chk("sat1_hready", 32'(hready), 32'd0);
      chk("sat1_hresp", 32'(hresp), 32'd1);
      chk("sat1_count", 32'(err_count), 32'hFFFF);
      tick();
      #1 chk("sat1_err2", 32'(hready), 32'd1);
      tick();
      haddr = 32'hF000_0000;
      #1;
      chk("sat2_hready", 32'(hready), 32'd0);
      chk("sat2_count", 32'(err_count), 32'hFFFF);
      chk("sat2_err_addr", err_addr, 32'h9000_0000);
      tick();
      #1 chk("sat2_err2", 32'(hready), 32'd1);
      tick();
      #1;
      chk("sat3_hready", 32'(hready), 32'd0);
      chk("sat3_count", 32'(err_count), 32'hFFFF);
      chk("sat3_err_addr", err_addr, 32'hF000_0000);

      // reset asserted while in DS_ERR1
      hresetn = 1'b0; htrans = 2'b00;
      #1;
      chk("rerr_hready", 32'(hready), 32'd1);
      chk("rerr_hresp", 32'(hresp), 32'd0);
      chk("rerr_count", 32'(err_count), 32'd0);
      chk("rerr_err_addr", err_addr, 32'd0);
      tick();
      hresetn = 1'b1; haddr = 32'h0000_0020; htrans = 2'b10;
      tick();
      htrans = 2'b00;
      #1;
      chk("post_hready", 32'(hready), 32'd1);
      chk("post_hrdata", hrdata, 32'hCAFE_0000);
      chk("post_hresp", 32'(hresp), 32'd0);
      chk("post_count", 32'(err_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
